bcd_chain_counter: RTL
======================

Name: bcd_chain_counter

Overview:
Parametrised multi-digit BCD up/down counter with a programmable terminal value. It generalises the single-digit counter stage into one block with a digit ripple, parallel load, direction control and a terminal flag. Default configuration is 4 digits counting 0 to 9675. It sits behind the display/digit-select logic and is stepped by a qualified carry/tick input.

Parameters:
DIGITS, 4, number of BCD digits, legal range 1..8.
MAX_VALUE, 9675, terminal count as a decimal integer; must be at most 10^DIGITS-1. Converted internally to a BCD constant.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
ena  input  1  global count enable.
carry  input  1  count step request; a step occurs when ena=1 and carry=1 on a rising clk edge.
dir  input  1  0 = count up, 1 = count down; sampled on the step edge.
load  input  1  synchronous parallel load strobe; independent of ena.
load_data  input  4*DIGITS  BCD load value, digit 0 in bits [3:0].
Qdata  output  4*DIGITS  current count, packed BCD, registered.
flag  output  1  terminal/wrap pulse, registered.
err  output  1  load-rejected pulse, registered.

Behaviour:
- Reset (rst=0, asynchronous): Qdata=0, flag=0, err=0 immediately. Release is synchronous to clk. No step or load is taken on the edge where rst is low.
- Priority on each edge: reset > load > step > hold.
- Load (load=1):
  - Accepted if every digit is ≤9 and the value is ≤MAX_VALUE. Qdata=load_data on that edge; flag=0; err=0.
  - Otherwise rejected: Qdata holds, err=1 for exactly one cycle.
  - A step requested in the same cycle is discarded in both cases.
- Step, up (dir=0):
  - Digit 0 increments. A digit at 9 becomes 0 and passes a carry to the next digit; the ripple completes in one cycle, with no intermediate values visible.
  - If Qdata==MAX_VALUE before the step: Qdata becomes 0 and flag=1 for one cycle. The pulse coincides with Qdata showing 0.
- Step, down (dir=1):
  - Digit 0 decrements. A digit at 0 becomes 9 and borrows from the next digit.
  - If Qdata==0 before the step: Qdata becomes MAX_VALUE and flag=1 for one cycle.
- Latency: one clk edge from a qualified step or load to updated Qdata. flag and err are aligned with that same edge.
- flag and err are 0 in every cycle with no wrap or rejection event. Back-to-back wraps (for example MAX_VALUE=0) give flag high on consecutive cycles.
- dir may change every cycle. No state depends on the previous direction.
- ena=0: steps are ignored; load still works.
- Qdata never holds an invalid BCD digit or a value above MAX_VALUE.
- Values that fall between the BCD boundaries are skipped naturally (for example 0x0099 up goes to 0x0100).

Optional Feature:
Macro BCD_SATURATE_EN.
- Defined: the counter saturates instead of wrapping.
  - Up at MAX_VALUE holds MAX_VALUE; down at 0 holds 0.
  - flag becomes a registered level: 1 whenever Qdata==MAX_VALUE (counting up) or Qdata==0 (counting down), evaluated from the post-update Qdata and the current dir.
  - Load behaviour is unchanged.
- Not defined: wrap-around behaviour as above, with flag as a one-cycle pulse.

Test Plan:
- Async reset mid-count: Qdata=0x0421, pull rst low between edges -> Qdata=0x0000, flag=0, err=0 with no clk edge; the count resumes from 0 after release.
- Up wrap: load 0x9674; three steps up -> Qdata 0x9675, then 0x0000 with flag=1 for that one cycle, then 0x0001 with flag=0.
- Decimal ripple: load 0x0999; one step up -> 0x1000; one step down -> 0x0999; flag stays 0 throughout.
- Down wrap: Qdata=0x0000, dir=1; one step -> 0x9675 with a flag pulse; next step -> 0x9674.
- Load rejection: load_data=0x9680 -> err pulse, Qdata unchanged; load_data=0x12A4 -> err pulse; load_data=0x5000 with carry=1 in the same cycle -> Qdata=0x5000, no step taken.
- Enable gating and saturate build: ena=0, carry=1 for 10 cycles -> Qdata holds. Then with BCD_SATURATE_EN defined, from 0x9675 step up 3 times -> Qdata holds 0x9675 and flag stays 1.

Source files
------------

// File: rtl/bcd_chain_counter.sv
// Multi-digit packed-BCD up/down counter with programmable terminal value, parallel load and wrap/reject pulses.
// Optional macro BCD_SATURATE_EN: saturate at the ends instead of wrapping, with flag as a level.
module bcd_chain_counter #(
    parameter int DIGITS    = 4,
    parameter int MAX_VALUE = 9675
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  carry,
    input  logic                  dir,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_data,
    output logic [4*DIGITS-1:0]   Qdata,
    output logic                  flag,
    output logic                  err
);

    localparam int W = 4 * DIGITS;

    function automatic logic [W-1:0] to_bcd(input int value);
        logic [W-1:0] result;
        int           remaining;
        result    = '0;
        remaining = value;
        for (int i = 0; i < DIGITS; i++) begin
            result[4*i +: 4] = 4'(remaining % 10);
            remaining        = remaining / 10;
        end
        return result;
    endfunction

    localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_VALUE);

    logic [W-1:0] inc_val;
    logic [W-1:0] dec_val;
    logic [W-1:0] next_q;
    logic         next_flag;
    logic         next_err;
    logic         ripple_c;
    logic         ripple_b;
    logic         load_ok;
    logic         step;
    logic         at_max;
    logic         at_zero;

    assign step    = ena & carry;
    assign at_max  = (Qdata == MAX_BCD);
    assign at_zero = (Qdata == '0);

    // Full-width increment/decrement with the digit ripple resolved in a single cycle.
    always_comb begin
        inc_val  = Qdata;
        dec_val  = Qdata;
        ripple_c = 1'b1;
        ripple_b = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (ripple_c) begin
                if (Qdata[4*i +: 4] == 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = Qdata[4*i +: 4] + 4'd1;
                    ripple_c          = 1'b0;
                end
            end
            if (ripple_b) begin
                if (Qdata[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = Qdata[4*i +: 4] - 4'd1;
                    ripple_b          = 1'b0;
                end
            end
        end
    end

    // With every digit valid, packed BCD orders the same as the decimal value it encodes.
    always_comb begin
        load_ok = (load_data <= MAX_BCD);
        for (int i = 0; i < DIGITS; i++) begin
            if (load_data[4*i +: 4] > 4'd9) begin
                load_ok = 1'b0;
            end
        end
    end

    always_comb begin
        next_q    = Qdata;
        next_flag = 1'b0;
        next_err  = 1'b0;
        if (load) begin
            if (load_ok) begin
                next_q = load_data;
            end else begin
                next_err = 1'b1;
            end
        end else if (step) begin
            if (!dir) begin
                if (at_max) begin
`ifdef BCD_SATURATE_EN
                    next_q = MAX_BCD;
`else
                    next_q    = '0;
                    next_flag = 1'b1;
`endif
                end else begin
                    next_q = inc_val;
                end
            end else begin
                if (at_zero) begin
`ifdef BCD_SATURATE_EN
                    next_q = '0;
`else
                    next_q    = MAX_BCD;
                    next_flag = 1'b1;
`endif
                end else begin
                    next_q = dec_val;
                end
            end
        end
`ifdef BCD_SATURATE_EN
        if (!(load && load_ok)) begin
            next_flag = dir ? (next_q == '0) : (next_q == MAX_BCD);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Qdata <= '0;
            flag  <= 1'b0;
            err   <= 1'b0;
        end else begin
            Qdata <= next_q;
            flag  <= next_flag;
            err   <= next_err;
        end
    end

endmodule
